// File: rtl/adcsnap_pkg.sv
// Shared types and status-word layout for the ADC snapshot capture controller.
// Imported by the write-port interface and the controller.
package adcsnap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        DONE
    } state_t;

    localparam int DONE_BIT  = 31;
    localparam int CAPT_BIT  = 30;
    localparam int ARMED_BIT = 29;
    localparam int CNT_LSB   = 0;
    localparam int CNT_W     = 17;

endpackage

// File: rtl/adcsnap_capture_ctrl_if.sv
// Snapshot buffer write port: address, data and write enable.
// The controller drives it (master); the external RAM receives it (slave).
interface adcsnap_capture_ctrl_if
    import adcsnap_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);

    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;

    modport master (
        output bram_addr,
        output bram_data,
        output bram_we
    );

    modport slave (
        input bram_addr,
        input bram_data,
        input bram_we
    );

endinterface

// File: rtl/adcsnap_capture_ctrl.sv
// ADC snapshot capture controller: arm, optional trigger, fill one buffer.
// Write port and status word are registered one cycle after the decision.
module adcsnap_capture_ctrl
    import adcsnap_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                   user_clk,
    input  logic                   user_rst_n,
    input  logic [31:0]            ctrl,
    input  logic                   trig,
    input  logic [DATA_W-1:0]      din,
    input  logic                   din_vld,
    adcsnap_capture_ctrl_if.master bram,
    output logic [31:0]            status
);

    if (ADDR_W < 4 || ADDR_W > 16) begin : g_bad_addr_w
        $error("ADDR_W must be within 4..16");
    end

    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              arm_q;
    logic              arm_edge;
    logic              qual;
    logic              go;
    logic              we_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n;
    logic [31:0]       status_n;
    logic              unused_ctrl;

    assign unused_ctrl = ^ctrl[31:3];

    assign arm_edge = ctrl[0] & ~arm_q;
    assign qual     = din_vld | ~ctrl[2];
    assign go       = qual & (trig | ~ctrl[1]);

    // State, sample count and arm edge-detect registers.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            arm_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            arm_q   <= ctrl[0];
        end
    end

    // Next state, next count and the write decision; arm edge wins over all.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        we_n    = 1'b0;
        addr_n  = cnt_q[ADDR_W-1:0];
        data_n  = din;
        if (arm_edge) begin
            state_n = ARMED;
            cnt_n   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_n = IDLE;
                end
                ARMED: begin
                    if (go) begin
                        we_n    = 1'b1;
                        addr_n  = '0;
                        cnt_n   = CNT_W'(1);
                        state_n = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (qual) begin
                        we_n  = 1'b1;
                        cnt_n = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == DEPTH) begin
                            state_n = DONE;
                        end
                    end
                end
                DONE: begin
                    state_n = DONE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Status word assembled from the current state and count.
    always_comb begin
        status_n                    = '0;
        status_n[DONE_BIT]          = (state_q == DONE);
        status_n[CAPT_BIT]          = (state_q == CAPTURE);
        status_n[ARMED_BIT]         = (state_q == ARMED);
        status_n[CNT_LSB +: CNT_W]  = cnt_q;
    end

    // Registered buffer write port and status output.
    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            bram.bram_we   <= 1'b0;
            bram.bram_addr <= '0;
            bram.bram_data <= '0;
            status         <= '0;
        end else begin
            bram.bram_we <= we_n;
            if (we_n) begin
                bram.bram_addr <= addr_n;
                bram.bram_data <= data_n;
            end
            status <= status_n;
        end
    end

endmodule

// File: doc/adcsnap_capture_ctrl.md
ADCSNAP_CAPTURE_CTRL -- requirements
Module: adcsnap_capture_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: snapshot buffer address width, legal range 4..16.
REQ-002 SHALL have parameter DATA_W, default 32: sample width passed to the buffer.
REQ-003 SHALL have port user_clk, input, 1: the single clock; all logic is in this domain.
REQ-004 SHALL have port user_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ctrl, input, 32: software control word; bit0 = arm, bit1 = trig_en (1 = wait for trig), bit2 = we_en (1 = honour din_vld, 0 = write every cycle).
REQ-006 SHALL have port trig, input, 1: capture trigger, level-sampled.
REQ-007 SHALL have port din, input, DATA_W: sample data.
REQ-008 SHALL have port din_vld, input, 1: sample valid.
REQ-009 SHALL have ports bram_addr (output, ADDR_W), bram_data (output, DATA_W) and bram_we (output, 1): buffer write port.
REQ-010 SHALL have port status, output, 32: status word feeding the simulink2ppc status register user_data_in.

Function
REQ-011 SHALL detect arm as the 0->1 transition of ctrl[0] between consecutive user_clk edges; a held level SHALL NOT re-arm.
REQ-012 SHALL implement states IDLE, ARMED, CAPTURE and DONE.
REQ-013 SHALL, on an arm edge in any state, enter ARMED and clear the sample count to 0 and done to 0; an arm edge during CAPTURE SHALL abort and restart.
REQ-014 SHALL define a qualified sample as (din_vld or not we_en).
REQ-015 SHALL, in ARMED, move to CAPTURE on the first qualified sample where (trig=1 or trig_en=0), and SHALL write that sample as sample 0.
REQ-016 SHALL, in CAPTURE, write every qualified sample at address = current count, then increment the count.
REQ-017 SHALL enter DONE on the cycle after the 2^ADDR_W-th write; count then equals 2^ADDR_W with no wrap, and no further writes occur.
REQ-018 SHALL leave DONE only on an arm edge, and SHALL leave IDLE only on an arm edge.
REQ-019 SHALL register the write port: bram_we, bram_addr and bram_data are valid exactly 1 cycle after the qualifying input cycle.
REQ-020 SHALL drive status[31] = done (state DONE), status[30] = capturing (state CAPTURE), status[29] = armed (state ARMED), status[28:17] = 0, and status[16:0] = count zero-extended.
REQ-021 SHALL register status, so it reflects the state and count 1 cycle after they change.
REQ-022 SHALL, when an arm edge and a qualified trigger coincide, give the arm edge priority: enter ARMED with no write.

Reset
REQ-023 SHALL, while user_rst_n = 0, asynchronously force state IDLE, count 0, edge-detect register 0, bram_we 0, bram_addr 0, bram_data 0 and status 0.
REQ-024 SHALL, on reset asserted mid-capture, discard the capture; after release the block stays in IDLE until a fresh arm edge.

Structure
REQ-025 SHALL place the state enumeration and the status bit-position constants (DONE_BIT = 31, CAPT_BIT = 30, ARMED_BIT = 29, CNT_LSB = 0, CNT_W = 17) in a shared package adcsnap_pkg.
REQ-026 SHALL be a single module with no sub-modules; the buffer RAM is external.

Verification
REQ-027 SHALL cover basic capture: ADDR_W = 4, ctrl = 0x1 (arm, trig_en = 0, we_en = 0), din counting from 0 -> 16 writes at addresses 0..15 with data 0..15, then status = 0x80000010.
REQ-028 SHALL cover triggered capture: ctrl = 0x3, trig pulsed at cycle 20 -> first bram_we at cycle 21 with din from cycle 20; status[29] = 1 before the trigger.
REQ-029 SHALL cover gated writes: ctrl = 0x5, din_vld toggling 1010… -> 16 writes take 32 cycles, and no write occurs on a din_vld = 0 cycle.
REQ-030 SHALL cover re-arm: an arm edge after 7 writes -> status = 0x20000000, count restarts at address 0; holding ctrl[0] = 1 does not re-arm after DONE.
REQ-031 SHALL cover reset mid-capture: user_rst_n low after 5 writes -> status = 0 and bram_we = 0 immediately (asynchronously); the block stays in IDLE after release.
REQ-032 SHALL cover coincidence: an arm edge on the same cycle as trig in ARMED -> no write that cycle, and the state remains ARMED.
